tlp_framer: RTL and testbench
=============================

# tlp_framer

Parametrised successor to the single-DW-per-cycle TLP transmitter. It accepts a whole TLP of 1..MAX_DW DWs through a valid/ready handshake. It then emits it as a byte-serial symbol stream: an STP token, an optional sequence number, every byte of every DW MSB-first, then END (good) or EDB (nullified). The stream carries downstream backpressure and sits between the transaction-layer TLP builder and the lane striping/scrambler stage.

## Interface
- MAX_DW, 8, maximum TLP length in DWs (≥1)
- STP_SYM, 8'hFB, start-of-TLP control symbol
- END_SYM, 8'hFD, good end control symbol
- EDB_SYM, 8'hFE, nullified end control symbol
- LW, $clog2(MAX_DW+1), width of in_len (derived localparam)

Ports. Clock is `clk`. Reset is `rst_n`: asynchronous assert, active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  TLP offered
- in_ready  out  1  framer can accept a TLP
- in_data  in  MAX_DW*32  TLP DWs; DW0 in [MAX_DW*32-1 -: 32]
- in_len  in  LW  DW count, legal 1..MAX_DW
- in_nullify  in  1  terminate with EDB instead of END
- sym_valid  out  1  symbol presented
- sym_ready  in  1  downstream accepts symbol
- sym_data  out  8  symbol byte
- sym_is_k  out  1  sym_data is a control symbol (STP/END/EDB)
- tlp_done  out  1  one-cycle pulse: TLP fully emitted
- tlp_err  out  1  one-cycle pulse: TLP rejected for illegal length

## Operation
- States: IDLE, STP, SEQ, DATA, TAIL. SEQ exists only with the macro enabled.
- IDLE:
  - in_ready=1, sym_valid=0.
  - On in_valid, capture in_data, in_len and in_nullify.
  - in_len==0 or in_len>MAX_DW: pulse tlp_err next cycle, stay IDLE, emit no symbols.
  - Legal length: go to STP.
- STP: present STP_SYM with sym_is_k=1. On handshake, go to SEQ (if enabled) else DATA.
- SEQ: two symbols, {4'h0, seq[11:8]} then seq[7:0], with sym_is_k=0.
- DATA:
  - Emit 4*in_len bytes, DW0 byte3 first, ending with the last DW's byte0.
  - Byte counter is $clog2(MAX_DW*4) bits wide. Advance on handshake only.
- TAIL:
  - Present END_SYM, or EDB_SYM if nullified, with sym_is_k=1.
  - On handshake go to IDLE and pulse tlp_done the following cycle.
- Backpressure: while sym_valid && !sym_ready, sym_data and sym_is_k hold stable. sym_valid never drops mid-TLP.
- Symbols per TLP: 2 + 4*len, plus 2 when the sequence number is enabled.
- Reset mid-TLP: all state is discarded immediately. No TAIL is emitted.

## Timing
- Reset values:
  - in_ready=1 (IDLE)
  - sym_valid=0, sym_data=8'h00, sym_is_k=0
  - tlp_done=0, tlp_err=0
  - seq=0
- All outputs are registered. in_ready is decoded from the state register.
- Accept at cycle T. STP is visible at T+1.
- With sym_ready held high, one symbol per cycle. The last symbol is at T+1+N-1, where N is the symbol count.
- Back-to-back:
  - The TAIL handshake cycle moves the state to IDLE.
  - in_ready=1 the next cycle, together with tlp_done.
  - Minimum gap between TLPs is one idle cycle (sym_valid=0).
- tlp_err is asserted exactly one cycle after the rejected accept. in_ready stays 1.

## Configuration
- TLP_FRAMER_SEQ_EN defined:
  - 12-bit sequence counter plus the SEQ state.
  - Counter increments mod 4096 on an END handshake only.
  - EDB handshakes and rejected TLPs leave it unchanged.
  - 4095 wraps to 0.
- TLP_FRAMER_SEQ_EN undefined: no SEQ state, no counter. STP is followed directly by data.

## Structure
- Package tlp_framer_pkg holds:
  - state enum tlp_framer_state_e
  - default token constants STP/END/EDB
  - sequence width constant SEQ_W=12
- Natural sub-module: tlp_seq_gen, which holds the counter and byte select. It is instantiated only under TLP_FRAMER_SEQ_EN.
- The rest is a single FSM plus a byte counter and a capture register.

## Test plan
- MAX_DW=8, no SEQ, len=1, data 32'hA1B2C3D4, sym_ready=1 -> FB(k), A1, B2, C3, D4, FD(k) on consecutive cycles; tlp_done pulses once.
- len=2 with in_nullify=1 -> STP, 8 data bytes, FE(k); with SEQ_EN the next TLP still carries the same seq.
- SEQ_EN, three good TLPs from reset -> sequence bytes 00 00, 00 01, 00 02; preload seq=4095 -> 0F FF, next 00 00.
- Random sym_ready stalls on len=8 -> all 34 symbols delivered in order; sym_data stable during every stall cycle.
- in_len=0 and in_len=9 -> tlp_err pulse each; no sym_valid; seq unchanged.
- rst_n asserted mid-DATA -> sym_valid=0 immediately; after release in_ready=1; a new TLP starts with STP.

Source files
------------

// File: rtl/tlp_framer_pkg.sv
// Shared types and constants for the TLP byte-serial framer.
package tlp_framer_pkg;

    // Framer FSM states; ST_SEQ is only reachable when TLP_FRAMER_SEQ_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STP  = 3'd1,
        ST_SEQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_TAIL = 3'd4
    } tlp_framer_state_e;

    // Default control tokens
    localparam logic [7:0] STP_SYM_DEF = 8'hFB;
    localparam logic [7:0] END_SYM_DEF = 8'hFD;
    localparam logic [7:0] EDB_SYM_DEF = 8'hFE;

    // Width of the link sequence number
    localparam int SEQ_W = 12;

endpackage

// File: rtl/tlp_seq_gen.sv
// Sequence number generator for the TLP framer (used only when
// TLP_FRAMER_SEQ_EN is defined). Holds the 12-bit counter, advances it on
// each good (END) completion and selects which of the two sequence bytes
// is presented: sel=0 -> {4'h0, seq[11:8]}, sel=1 -> seq[7:0].
module tlp_seq_gen
    import tlp_framer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       sel,
    output logic [7:0] seq_byte
);

    logic [SEQ_W-1:0] seq_reg;
    logic [15:0]      seq_wide;

    // Counter wraps naturally from 4095 to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_reg <= '0;
        end else if (inc) begin
            seq_reg <= seq_reg + SEQ_W'(1);
        end
    end

    assign seq_wide = 16'(seq_reg);
    assign seq_byte = sel ? seq_wide[7:0] : seq_wide[15:8];

endmodule

// File: rtl/tlp_framer.sv
// TLP framer: accepts a whole TLP of 1..MAX_DW DWs and serialises it as
// STP, [seq hi, seq lo], data bytes MSB-first, END/EDB. Outputs are
// registered from the next-state decode so they stay stable under
// backpressure. Optional macro: TLP_FRAMER_SEQ_EN adds the sequence number.
module tlp_framer
    import tlp_framer_pkg::*;
#(
    parameter int         MAX_DW  = 8,
    parameter logic [7:0] STP_SYM = STP_SYM_DEF,
    parameter logic [7:0] END_SYM = END_SYM_DEF,
    parameter logic [7:0] EDB_SYM = EDB_SYM_DEF,
    localparam int        LW      = $clog2(MAX_DW + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MAX_DW*32-1:0]  in_data,
    input  logic [LW-1:0]         in_len,
    input  logic                  in_nullify,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic [7:0]            sym_data,
    output logic                  sym_is_k,
    output logic                  tlp_done,
    output logic                  tlp_err
);

    localparam int DBITS = MAX_DW * 32;
    localparam int BW    = $clog2(MAX_DW * 4);

    tlp_framer_state_e state_reg, state_next;
    logic [BW-1:0]     cnt_reg, cnt_next;
    logic [DBITS-1:0]  data_reg;
    logic [LW-1:0]     len_reg;
    logic              nullify_reg;
    logic              sym_valid_reg;
    logic [7:0]        sym_data_reg, sym_data_next;
    logic              sym_is_k_reg, sym_is_k_next;
    logic              done_reg, err_reg;

    logic              hs, accept, len_ok, last_byte;
    logic [LW+1:0]     len_x4;
    logic [DBITS-1:0]  data_shifted;
    logic [7:0]        seq_byte;

    assign hs        = sym_valid_reg && sym_ready;
    assign accept    = (state_reg == ST_IDLE) && in_valid;
    assign len_ok    = (in_len != '0) && (in_len <= LW'(MAX_DW));
    assign len_x4    = {len_reg, 2'b00};
    assign last_byte = ((LW+2)'(cnt_reg) == (len_x4 - (LW+2)'(1)));

    // Byte index cnt_next selects DW (cnt/4) byte (3 - cnt%4): a left shift
    // by 8*cnt puts that byte at the top of the captured vector.
    assign data_shifted = data_reg << {cnt_next, 3'b000};

`ifdef TLP_FRAMER_SEQ_EN
    logic end_hs;
    assign end_hs = (state_reg == ST_TAIL) && hs && !nullify_reg;

    tlp_seq_gen u_seq_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (end_hs),
        .sel      (cnt_next[0]),
        .seq_byte (seq_byte)
    );
`else
    assign seq_byte = 8'h00;
`endif

    // Next-state and byte counter; everything advances only on a handshake
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && len_ok) begin
                    state_next = ST_STP;
                    cnt_next   = '0;
                end
            end
            ST_STP: begin
                if (hs) begin
`ifdef TLP_FRAMER_SEQ_EN
                    state_next = ST_SEQ;
`else
                    state_next = ST_DATA;
`endif
                    cnt_next = '0;
                end
            end
            ST_SEQ: begin
                if (hs) begin
                    if (cnt_reg[0]) begin
                        state_next = ST_DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + BW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (hs) begin
                    if (last_byte) begin
                        state_next = ST_TAIL;
                    end else begin
                        cnt_next = cnt_reg + BW'(1);
                    end
                end
            end
            ST_TAIL: begin
                if (hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Symbol to present in the state being entered (registered below)
    always_comb begin
        sym_data_next = 8'h00;
        sym_is_k_next = 1'b0;
        case (state_next)
            ST_STP: begin
                sym_data_next = STP_SYM;
                sym_is_k_next = 1'b1;
            end
            ST_SEQ:  sym_data_next = seq_byte;
            ST_DATA: sym_data_next = data_shifted[DBITS-1 -: 8];
            ST_TAIL: begin
                sym_data_next = nullify_reg ? EDB_SYM : END_SYM;
                sym_is_k_next = 1'b1;
            end
            default: ;
        endcase
    end

    // State, capture register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            data_reg      <= '0;
            len_reg       <= '0;
            nullify_reg   <= 1'b0;
            sym_valid_reg <= 1'b0;
            sym_data_reg  <= 8'h00;
            sym_is_k_reg  <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                data_reg    <= in_data;
                len_reg     <= in_len;
                nullify_reg <= in_nullify;
            end
            sym_valid_reg <= (state_next != ST_IDLE);
            sym_data_reg  <= sym_data_next;
            sym_is_k_reg  <= sym_is_k_next;
            done_reg      <= (state_reg == ST_TAIL) && hs;
            err_reg       <= accept && !len_ok;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign sym_valid = sym_valid_reg;
    assign sym_data  = sym_data_reg;
    assign sym_is_k  = sym_is_k_reg;
    assign tlp_done  = done_reg;
    assign tlp_err   = err_reg;

endmodule

// File: tb/tb_tlp_framer.sv
// Self-checking bench for tlp_framer (MAX_DW=8). Sequence-number checks are
// active when TLP_FRAMER_SEQ_EN is defined. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_tlp_framer;

    localparam int MAX_DW = 8;
    localparam int W      = MAX_DW * 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [3:0]   in_len = 4'd0;
    logic         in_nullify = 1'b0;
    logic         sym_valid;
    logic         sym_ready = 1'b1;
    logic [7:0]   sym_data;
    logic         sym_is_k;
    logic         tlp_done;
    logic         tlp_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];
`ifdef TLP_FRAMER_SEQ_EN
    logic [11:0] seq_model = 12'h000;
`endif

    always #5 clk = ~clk;

    tlp_framer #(.MAX_DW(MAX_DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_nullify (in_nullify),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_data   (sym_data),
        .sym_is_k   (sym_is_k),
        .tlp_done   (tlp_done),
        .tlp_err    (tlp_err)
    );

    // Expected symbol list {is_k, byte} for one TLP
    task automatic build_exp(input logic [W-1:0] data, input int len, input bit nul);
        logic [W-1:0] tmp;
        exp_q.delete();
        exp_q.push_back({1'b1, 8'hFB});
`ifdef TLP_FRAMER_SEQ_EN
        exp_q.push_back({1'b0, 4'h0, seq_model[11:8]});
        exp_q.push_back({1'b0, seq_model[7:0]});
`endif
        for (int i = 0; i < 4 * len; i++) begin
            tmp = data << (8 * i);
            exp_q.push_back({1'b0, tmp[W-1 -: 8]});
        end
        exp_q.push_back(nul ? {1'b1, 8'hFE} : {1'b1, 8'hFD});
    endtask

    // Present one TLP for a single cycle (called on a falling edge)
    task automatic offer(input logic [W-1:0] data, input int len, input bit nul);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL offer_ready: in_ready=%b required 1", in_ready);
        end
        in_valid   = 1'b1;
        in_data    = data;
        in_len     = 4'(len);
        in_nullify = nul;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Send a TLP and check every symbol, stability under stalls and completion
    task automatic run_tlp(input string name, input logic [W-1:0] data, input int len,
                           input bit nul, input bit stall);
        int idx = 0;
        int cyc = 0;
        int done_seen = 0;
        bit held = 1'b0;
        logic [7:0] held_data = 8'h00;
        logic held_k = 1'b0;
        build_exp(data, len, nul);
        offer(data, len, nul);
        while (idx < exp_q.size() && cyc < 300) begin
            n_checks++;
            if (sym_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_valid: sym_valid=%b at symbol %0d required 1", name, sym_valid, idx);
            end
            if (held) begin
                n_checks++;
                if ({sym_is_k, sym_data} !== {held_k, held_data}) begin
                    n_fail++;
                    $display("FAIL %s_stable: k=%b data=%h required k=%b data=%h",
                             name, sym_is_k, sym_data, held_k, held_data);
                end
            end
            if (tlp_done === 1'b1) done_seen++;
            sym_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (sym_ready) begin
                n_checks++;
                if ({sym_is_k, sym_data} !== exp_q[idx]) begin
                    n_fail++;
                    $display("FAIL %s_sym%0d: k=%b data=%h required k=%b data=%h",
                             name, idx, sym_is_k, sym_data, exp_q[idx][8], exp_q[idx][7:0]);
                end
                idx++;
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = sym_data;
                held_k    = sym_is_k;
            end
            @(negedge clk);
            cyc++;
        end
        sym_ready = 1'b1;
        n_checks++;
        if (idx != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_timeout: delivered %0d symbols required %0d", name, idx, exp_q.size());
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL %s_early_done: tlp_done seen %0d times mid-TLP required 0", name, done_seen);
        end
        n_checks++;
        if (tlp_done !== 1'b1 || in_ready !== 1'b1 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: done=%b in_ready=%b sym_valid=%b required 1 1 0",
                     name, tlp_done, in_ready, sym_valid);
        end
        if (!stall) begin
            n_checks++;
            if (cyc != exp_q.size()) begin
                n_fail++;
                $display("FAIL %s_cycles: took %0d cycles required %0d", name, cyc, exp_q.size());
            end
        end
`ifdef TLP_FRAMER_SEQ_EN
        if (!nul) seq_model = seq_model + 12'd1;
`endif
    endtask

    // One idle cycle; tlp_done must have been a single-cycle pulse
    task automatic idle_check(input string name);
        @(negedge clk);
        n_checks++;
        if (tlp_done !== 1'b0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: done=%b sym_valid=%b required 0 0", name, tlp_done, sym_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({in_ready, sym_valid, sym_data, sym_is_k, tlp_done, tlp_err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h k=%b done=%b err=%b required 1 0 00 0 0 0",
                     in_ready, sym_valid, sym_data, sym_is_k, tlp_done, tlp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_tlp("len1", {32'hA1B2C3D4, {7{32'hDEADBEEF}}}, 1, 1'b0, 1'b0);
        idle_check("len1");
    endtask

    task automatic test_nullify();
        run_tlp("null2", {32'h11223344, 32'h55667788, {6{32'hCAFEF00D}}}, 2, 1'b1, 1'b0);
        idle_check("null2");
        run_tlp("after_null", {32'h0BADC0DE, {7{32'h5A5A5A5A}}}, 1, 1'b0, 1'b0);
        idle_check("after_null");
    endtask

    task automatic test_stall();
        logic [W-1:0] d = '0;
        for (int i = 0; i < MAX_DW; i++) d = (d << 32) | W'(32'h01020304 + i * 32'h10101010);
        run_tlp("stall8", d, 8, 1'b0, 1'b1);
        idle_check("stall8");
    endtask

    task automatic test_illegal();
        int lens[2] = '{0, 9};
        for (int k = 0; k < 2; k++) begin
            offer({8{32'h12345678}}, lens[k], 1'b0);
            n_checks++;
            if (tlp_err !== 1'b1 || sym_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_len%0d: err=%b sym_valid=%b in_ready=%b required 1 0 1",
                         lens[k], tlp_err, sym_valid, in_ready);
            end
            @(negedge clk);
            n_checks++;
            if (tlp_err !== 1'b0 || sym_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_len%0d_pulse: err=%b sym_valid=%b required 0 0",
                         lens[k], tlp_err, sym_valid);
            end
        end
        run_tlp("after_err", {32'hFEEDFACE, {7{32'h00000000}}}, 1, 1'b0, 1'b0);
        idle_check("after_err");
    endtask

    task automatic test_back_to_back();
        run_tlp("b2b_a", {32'h01234567, 32'h89ABCDEF, {6{32'h0}}}, 2, 1'b0, 1'b0);
        run_tlp("b2b_b", {32'hF0E1D2C3, {7{32'h0}}}, 1, 1'b0, 1'b0);
        idle_check("b2b_b");
    endtask

    task automatic test_reset_mid();
        offer({8{32'h77777777}}, 8, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sym_valid !== 1'b0 || in_ready !== 1'b1 || sym_is_k !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: sym_valid=%b in_ready=%b k=%b required 0 1 0", sym_valid, in_ready, sym_is_k);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef TLP_FRAMER_SEQ_EN
        seq_model = 12'h000;
`endif
        idle_check("reset_mid");
        run_tlp("post_reset", {32'h9ABCDEF0, {7{32'h11111111}}}, 1, 1'b0, 1'b0);
        idle_check("post_reset");
    endtask

`ifdef TLP_FRAMER_SEQ_EN
    task automatic test_seq();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seq_model = 12'h000;
        @(negedge clk);
        for (int t = 0; t < 3; t++) run_tlp("seq_first", {32'h00000000 + t, {7{32'h0}}}, 1, 1'b0, 1'b0);
        while (seq_model != 12'hFFF) run_tlp("seq_fill", {8{32'h3C3C3C3C}}, 1, 1'b0, 1'b0);
        run_tlp("seq_4095", {32'hAABBCCDD, {7{32'h0}}}, 1, 1'b0, 1'b0);
        run_tlp("seq_wrap", {32'hDDCCBBAA, {7{32'h0}}}, 1, 1'b0, 1'b0);
        idle_check("seq_wrap");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_nullify();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef TLP_FRAMER_SEQ_EN
        test_seq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
